// File: rtl/irq_ctrl.sv
// irq_ctrl: N-channel interrupt controller for the 6502 synchronous bus.
// Edge/level sources with sticky pending bits, masks, and a read-to-acknowledge priority vector.
module irq_ctrl #(
  parameter int          N_CH        = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] NMI_MASK    = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     addr,
  input  logic [7:0]      wdata,
  input  logic            rw,
  output logic [7:0]      rdata,
  output logic            rd_hit,
  input  logic [N_CH-1:0] src,
  output logic            irq,
  output logic            nmi
);

  // Channel state is kept 16 bits wide; bits at or above N_CH are forced to zero.
  localparam logic [15:0] CH_MASK = (N_CH >= 16) ? 16'hFFFF
                                                 : 16'((32'd1 << N_CH) - 32'd1);

  localparam logic [2:0] OFF_PEND_L = 3'd0;
  localparam logic [2:0] OFF_PEND_H = 3'd1;
  localparam logic [2:0] OFF_MASK_L = 3'd2;
  localparam logic [2:0] OFF_MASK_H = 3'd3;
  localparam logic [2:0] OFF_MODE_L = 3'd4;
  localparam logic [2:0] OFF_MODE_H = 3'd5;
  localparam logic [2:0] OFF_VEC    = 3'd6;
  localparam logic [2:0] OFF_CTRL   = 3'd7;

  logic [15:0] src_w;
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] s;
  logic [15:0] prev;
  logic [15:0] rise;

  logic [15:0] pend;
  logic [15:0] mask;
  logic [15:0] mode;
  logic        ge;

  logic        hit;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  off;

  logic [15:0] act;
  logic        vec_any;
  logic [3:0]  vec_idx;
  logic [7:0]  vec_val;
  logic        ack;
  logic [15:0] ack_bits;

  logic [15:0] mask_nxt;
  logic [15:0] mode_nxt;
  logic        ge_nxt;
  logic [15:0] w1c;
  logic [15:0] clr;
  logic [15:0] pend_nxt;
  logic [7:0]  rd_val;

  assign src_w = 16'(src);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev <= '0;
    end else begin
      sync_q[0] <= src_w & CH_MASK;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;

  assign hit   = (addr[15:3] == BASE_ADDR[15:3]);
  assign off   = addr[2:0];
  assign wr_en = hit & ~rw;
  assign rd_en = hit & rw;

  // Lowest active channel wins; the vector ignores GE and NMI routing.
  assign act = pend & mask;

  always_comb begin
    vec_any = 1'b0;
    vec_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) begin
        vec_any = 1'b1;
        vec_idx = 4'(i);
      end
    end
  end

  assign vec_val = vec_any ? {4'b0000, vec_idx} : 8'h80;

  // Every VEC read acknowledges, including dummy reads issued by the core.
  assign ack = rd_en & (off == OFF_VEC) & vec_any;

  always_comb begin
    ack_bits = '0;
    if (ack) begin
      ack_bits[vec_idx] = 1'b1;
    end
  end

  always_comb begin
    mask_nxt = mask;
    mode_nxt = mode;
    ge_nxt   = ge;
    w1c      = '0;
    if (wr_en) begin
      case (off)
        OFF_PEND_L: w1c[7:0]       = wdata;
        OFF_PEND_H: w1c[15:8]      = wdata;
        OFF_MASK_L: mask_nxt[7:0]  = wdata;
        OFF_MASK_H: mask_nxt[15:8] = wdata;
        OFF_MODE_L: mode_nxt[7:0]  = wdata;
        OFF_MODE_H: mode_nxt[15:8] = wdata;
        OFF_CTRL:   ge_nxt         = wdata[0];
        default:    ;
      endcase
    end
    mask_nxt = mask_nxt & CH_MASK;
    mode_nxt = mode_nxt & CH_MASK;
    w1c      = w1c & CH_MASK;
  end

  assign clr = w1c | ack_bits;

  // Level bits track the source; a level-to-edge switch drops the stale level; set beats clear.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      if (!mode_nxt[i]) begin
        pend_nxt[i] = s[i];
      end else if (!mode[i]) begin
        pend_nxt[i] = rise[i];
      end else begin
        pend_nxt[i] = rise[i] | (pend[i] & ~clr[i]);
      end
    end
    pend_nxt = pend_nxt & CH_MASK;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_PEND_L: rd_val = pend[7:0];
      OFF_PEND_H: rd_val = pend[15:8];
      OFF_MASK_L: rd_val = mask[7:0];
      OFF_MASK_H: rd_val = mask[15:8];
      OFF_MODE_L: rd_val = mode[7:0];
      OFF_MODE_H: rd_val = mode[15:8];
      OFF_VEC:    rd_val = vec_val;
      OFF_CTRL:   rd_val = {7'b0000000, ge};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      mask   <= '0;
      mode   <= CH_MASK;
      ge     <= 1'b0;
      rdata  <= '0;
      rd_hit <= 1'b0;
      irq    <= 1'b0;
      nmi    <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      mask   <= mask_nxt;
      mode   <= mode_nxt;
      ge     <= ge_nxt;
      rd_hit <= rd_en;
      rdata  <= rd_en ? rd_val : 8'h00;
      irq    <= ge & |(act & ~NMI_MASK);
      nmi    <= ge & |(act & NMI_MASK);
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus randomized bench for irq_ctrl against a per-cycle reference model.
// The model applies the register-map rules to delayed source samples each clock edge.
module tb_irq_ctrl;

  localparam int          N_CH = 16;
  localparam int          SS   = 2;
  localparam logic [15:0] BASE = 16'hD000;
  localparam logic [15:0] NMI  = 16'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw;
  logic [7:0]  rdata;
  logic        rd_hit;
  logic [15:0] src;
  logic        irq;
  logic        nmi;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  irq_ctrl #(
    .N_CH(N_CH),
    .BASE_ADDR(BASE),
    .SYNC_STAGES(SS),
    .NMI_MASK(NMI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wdata(wdata),
    .rw(rw),
    .rdata(rdata),
    .rd_hit(rd_hit),
    .src(src),
    .irq(irq),
    .nmi(nmi)
  );

  // Reference model state.
  logic [15:0] m_pend, m_mask, m_mode;
  logic        m_ge;
  logic [7:0]  m_rdata;
  logic        m_rd_hit, m_irq, m_nmi;
  logic [15:0] hist [0:SS];
  logic [15:0] ms, mprev, mrise, mact, mclr, mmode_new, mpend_new;
  logic [7:0]  mvec, mrd;

  // hist[k] holds the source sample taken k+1 edges ago.
  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_mask = '0; m_mode = 16'hFFFF; m_ge = 1'b0;
      m_rdata = '0; m_rd_hit = 1'b0; m_irq = 1'b0; m_nmi = 1'b0;
      for (int k = 0; k <= SS; k++) hist[k] = '0;
    end else begin
      ms    = hist[SS-1];
      mprev = hist[SS];
      for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = src;
      mrise = ms & ~mprev;
      mact  = m_pend & m_mask;
      mvec  = 8'h80;
      for (int i = 15; i >= 0; i--) if (mact[i]) mvec = 8'(i);
      m_irq = m_ge & |(mact & ~NMI);
      m_nmi = m_ge & |(mact & NMI);
      mclr = '0;
      mmode_new = m_mode;
      m_rdata = 8'h00;
      m_rd_hit = 1'b0;
      if (addr[15:3] == BASE[15:3]) begin
        if (rw) begin
          case (addr[2:0])
            3'd0: mrd = m_pend[7:0];
            3'd1: mrd = m_pend[15:8];
            3'd2: mrd = m_mask[7:0];
            3'd3: mrd = m_mask[15:8];
            3'd4: mrd = m_mode[7:0];
            3'd5: mrd = m_mode[15:8];
            3'd6: mrd = mvec;
            default: mrd = {7'b0000000, m_ge};
          endcase
          m_rdata = mrd;
          m_rd_hit = 1'b1;
          if (addr[2:0] == 3'd6 && mvec != 8'h80) mclr[mvec[3:0]] = 1'b1;
        end else begin
          case (addr[2:0])
            3'd0: mclr[7:0] = wdata;
            3'd1: mclr[15:8] = wdata;
            3'd2: m_mask[7:0] = wdata;
            3'd3: m_mask[15:8] = wdata;
            3'd4: mmode_new[7:0] = wdata;
            3'd5: mmode_new[15:8] = wdata;
            3'd7: m_ge = wdata[0];
            default: ;
          endcase
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (!mmode_new[i])   mpend_new[i] = ms[i];
        else if (!m_mode[i]) mpend_new[i] = mrise[i];
        else                 mpend_new[i] = mrise[i] | (m_pend[i] & ~mclr[i]);
      end
      m_pend = mpend_new;
      m_mode = mmode_new;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive, clock, then compare every output against the model.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic r);
    addr = a; wdata = d; rw = r;
    @(posedge clk);
    @(negedge clk);
    checkOutput("model_rdata", 16'(rdata), 16'(m_rdata));
    checkOutput("model_rd_hit", 16'(rd_hit), 16'(m_rd_hit));
    checkOutput("model_irq", 16'(irq), 16'(m_irq));
    checkOutput("model_nmi", 16'(nmi), 16'(m_nmi));
  endtask

  task automatic idle();
    applyStimulus(16'h0000, 8'h00, 1'b1);
  endtask

  task automatic busWrite(input logic [2:0] o, input logic [7:0] d);
    applyStimulus({BASE[15:3], o}, d, 1'b0);
  endtask

  task automatic readCheck(input logic [2:0] o, input logic [7:0] exp, input string tag);
    applyStimulus({BASE[15:3], o}, 8'h00, 1'b1);
    checkOutput({tag, "_hit"}, 16'(rd_hit), 16'h0001);
    checkOutput(tag, 16'(rdata), 16'(exp));
  endtask

  initial begin
    logic [7:0]  reset_vals [8];
    logic [15:0] ra;
    logic [2:0]  ro;
    logic        rr;
    reset_vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h00};
    rst = 1'b1; src = '0; addr = '0; wdata = '0; rw = 1'b1;

    // Reset defaults.
    idle();
    checkOutput("rst_irq", 16'(irq), 16'h0000);
    checkOutput("rst_nmi", 16'(nmi), 16'h0000);
    rst = 1'b0;
    for (int o = 0; o < 8; o++) readCheck(3'(o), reset_vals[o], "rst_reg");

    // Edge capture and latency.
    busWrite(3'd2, 8'h04);
    busWrite(3'd7, 8'h01);
    src = 16'h0004;
    for (int k = 1; k <= SS + 2; k++) begin
      if (k == 4) src = 16'h0000;
      idle();
      checkOutput("edge_irq_latency", 16'(irq), (k == SS + 2) ? 16'h0001 : 16'h0000);
    end
    src = 16'h0000;
    readCheck(3'd0, 8'h04, "edge_pend");
    readCheck(3'd6, 8'h02, "edge_vec");
    checkOutput("edge_irq_at_ack", 16'(irq), 16'h0001);
    idle();
    checkOutput("edge_irq_after_ack", 16'(irq), 16'h0000);
    readCheck(3'd0, 8'h00, "edge_pend_cleared");

    // Priority and acknowledge order.
    busWrite(3'd2, 8'h22);
    busWrite(3'd3, 8'h02);
    src = 16'h0222;
    repeat (3) idle();
    src = 16'h0000;
    idle();
    checkOutput("prio_irq", 16'(irq), 16'h0001);
    readCheck(3'd6, 8'h01, "prio_vec1");
    readCheck(3'd6, 8'h05, "prio_vec5");
    readCheck(3'd6, 8'h09, "prio_vec9");
    checkOutput("prio_irq_third", 16'(irq), 16'h0001);
    readCheck(3'd6, 8'h80, "prio_vec_none");
    checkOutput("prio_irq_drop", 16'(irq), 16'h0000);

    // Level mode.
    busWrite(3'd4, 8'h00);
    busWrite(3'd2, 8'h08);
    src = 16'h0008;
    repeat (4) idle();
    readCheck(3'd0, 8'h08, "level_pend");
    busWrite(3'd0, 8'h08);
    readCheck(3'd0, 8'h08, "level_w1c_ignored");
    checkOutput("level_irq", 16'(irq), 16'h0001);
    src = 16'h0000;
    for (int k = 1; k <= SS + 2; k++) begin
      idle();
      checkOutput("level_irq_fall", 16'(irq), (k == SS + 2) ? 16'h0000 : 16'h0001);
    end
    busWrite(3'd4, 8'hFF);

    // Set/clear collision and NMI routing.
    busWrite(3'd2, 8'h01);
    src = 16'h0001;
    repeat (3) idle();
    src = 16'h0000;
    idle();
    checkOutput("nmi_route", 16'(nmi), 16'h0001);
    checkOutput("nmi_no_irq", 16'(irq), 16'h0000);
    idle();
    src = 16'h0001;
    repeat (2) idle();
    busWrite(3'd0, 8'h01);
    readCheck(3'd0, 8'h01, "collide_pend");
    checkOutput("collide_nmi", 16'(nmi), 16'h0001);
    checkOutput("collide_irq", 16'(irq), 16'h0000);
    src = 16'h0000;
    repeat (2) idle();
    busWrite(3'd0, 8'h01);
    readCheck(3'd0, 8'h00, "w1c_pend");
    checkOutput("w1c_nmi", 16'(nmi), 16'h0000);

    // Reset mid-operation with a source held high.
    busWrite(3'd2, 8'h80);
    src = 16'h0080;
    repeat (4) idle();
    checkOutput("pre_rst_irq", 16'(irq), 16'h0001);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("mid_rst_irq", 16'(irq), 16'h0000);
    checkOutput("mid_rst_nmi", 16'(nmi), 16'h0000);
    readCheck(3'd0, 8'h00, "rel_pend_e1");
    readCheck(3'd2, 8'h00, "rel_mask_e2");
    readCheck(3'd0, 8'h00, "rel_pend_e3");
    readCheck(3'd0, 8'h80, "rel_pend_e4");
    readCheck(3'd7, 8'h00, "rel_ctrl");
    src = 16'h0000;

    // Randomized traffic checked against the model every cycle.
    busWrite(3'd7, 8'h01);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) src = src ^ (16'h0001 << $urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      rr  = ($urandom_range(0, 3) != 0);
      ro  = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {BASE[15:3], ro};
      applyStimulus(ra, 8'($urandom), rr);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised N-channel interrupt controller. It aggregates peripheral interrupt sources into the 6502 core's `irq` and `nmi` pins.
- It is memory-mapped on the core's synchronous bus: the address is presented in one cycle and read data is returned registered on the next cycle.
- Each channel has a selectable edge/level mode, a per-channel mask, sticky pending bits, and a priority-encoded vector register whose read acknowledges the interrupt.

Parameters:
- N_CH, 8, number of source channels (1..16).
- BASE_ADDR, 16'hD000, base of the 8-byte register window. Must be 8-aligned.
- SYNC_STAGES, 2, synchroniser flops per source (>=1).
- NMI_MASK, 16'h0000, channels whose bit is set here drive `nmi`; all others drive `irq`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr  in  16  core address bus
- wdata  in  8  core write data (core `data_o`)
- rw  in  1  1=read, 0=write (core `rw`)
- rdata  out  8  registered read data
- rd_hit  out  1  registered; 1 when `rdata` is valid for this block (bus mux select)
- src  in  N_CH  asynchronous interrupt sources, active high
- irq  out  1  registered IRQ request to core
- nmi  out  1  registered NMI request to core

Behaviour:
- Reset: `rst` is synchronous, active-high; clock is `clk`. In reset, all of the following clear to 0: pend, mask, ctrl, synchroniser flops, previous-level flops, `rdata`, `rd_hit`, `irq`, `nmi`. `mode` resets to all-1 (edge).
- Reset asserted mid-operation discards all pending state the same edge.
- A source held high through reset registers one edge after release.
- Register map (offset from BASE_ADDR):
  - 0 PEND_L, 1 PEND_H
  - 2 MASK_L, 3 MASK_H (1=enabled)
  - 4 MODE_L, 5 MODE_H (1=edge, 0=level)
  - 6 VEC
  - 7 CTRL (bit0 = global enable GE; other bits read 0)
- Bits at or above N_CH read 0 and ignore writes. Addresses outside BASE..BASE+7 are not decoded.
- Decode: hit = (addr[15:3] == BASE_ADDR[15:3]).
- Write: when rw=0 and hit, the write takes effect at the clock edge.
  - MASK, MODE and CTRL are overwritten.
  - PEND is write-1-to-clear, and applies to edge-mode bits only.
- Read: when rw=1 and hit, the next cycle has rd_hit=1 and rdata=register value (registered; one-cycle latency). Otherwise rd_hit=0 and rdata holds 0.
- Read data for PEND and VEC reflects state before that edge's updates.
- Synchronisation: s = src delayed by SYNC_STAGES flops; prev = s delayed by 1.
- Edge mode: pend[i] sets on s[i] & ~prev[i]. It clears on a W1C write or a VEC acknowledge. If set and clear occur the same cycle, set wins.
- Level mode: pend[i] = s[i] each cycle, and is not clearable. Switching edge to level overwrites pend[i] with s[i] the next edge. Switching level to edge clears pend[i].
- Active set: act = pend & mask.
- VEC read value:
  - lowest index i with act[i]=1 gives {1'b0, 3'b0, i[3:0]};
  - none active gives 8'h80.
  - VEC ignores GE and NMI_MASK.
- VEC acknowledge: every rw=1 cycle with addr=BASE+6 clears pend[i] for the reported channel if it is in edge mode. Core dummy reads count as acknowledges.
- Outputs:
  - irq <= GE & |(act & ~NMI_MASK)
  - nmi <= GE & |(act & NMI_MASK)
  - Both are registered, one cycle after pend updates.
- Latency: a src rising edge gives pend set after SYNC_STAGES+1 clock edges, and irq/nmi asserted after SYNC_STAGES+2.
- Acknowledge/clear: irq deasserts the edge after the clearing edge if no other channel remains active.
- Pulse width: src pulses shorter than one clk are not guaranteed to be captured. Pulses of at least one clk are captured exactly once per rising edge.

Test Plan:
- Reset defaults: after rst, read offsets 0..7 -> rd_hit one cycle later; values 00,00,00,00,FF,FF,80,00 with N_CH=16; irq=0, nmi=0.
- Edge capture and latency: MASK_L=0x04, CTRL=1, pulse src[2] high 3 cycles -> PEND_L=0x04; irq rises exactly SYNC_STAGES+2 edges after src rise; VEC read returns 0x02; irq falls next cycle; PEND_L then reads 0x00.
- Priority and ack sequence: edges on ch1, ch5 and ch9 simultaneously, all masked on -> successive VEC reads give 0x01, 0x05, 0x09, 0x80; irq drops after the third ack.
- Level mode: MODE_L=0x00, src[3] held high -> PEND_L=0x08; W1C of 0x08 has no effect; irq stays 1 until src[3] drops, then deasserts after SYNC_STAGES+2 edges.
- Set/clear collision and NMI routing: NMI_MASK=0x0001; new edge on ch0 at the same edge as a W1C of bit0 -> pend stays 1, nmi=1, irq=0.
- Reset mid-operation: with GE=1 and ch7 pending, assert rst one cycle -> pend, mask, irq and nmi all 0 next cycle; src[7] held high -> pend[7] sets SYNC_STAGES+1 edges after release.
